// File: rtl/sprite_fetch_arb.sv
// Round-robin burst arbiter sharing one 16x16 sprite ROM between sprite engines.
// Define SPRITE_ARB_FIXED_PRIO_EN to make the lowest-index requester always win.
module sprite_fetch_arb #(
  parameter int NUM_REQ = 4,
  parameter int FRAME_W = 2,
  parameter int COLOR_W = 12,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*4-1:0]       req_row,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         ack,
  output logic [3:0]                 rom_row,
  output logic [3:0]                 rom_col,
  output logic [FRAME_W-1:0]         rom_frame,
  input  logic [COLOR_W-1:0]         rom_data,
  output logic                       pix_valid,
  output logic [ID_W-1:0]            pix_id,
  output logic [3:0]                 pix_col,
  output logic [COLOR_W-1:0]         pix_data,
  output logic                       pix_last,
  output logic                       busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           rom_row_q, rom_row_d;
  logic [3:0]           rom_col_q, rom_col_d;
  logic [FRAME_W-1:0]   rom_frame_q, rom_frame_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
`endif
  logic                 s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d;
  logic [3:0]           s1_col_q, s1_col_d;
  logic                 s1_last_q, s1_last_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [ID_W-1:0]      pix_id_q, pix_id_d;
  logic [3:0]           pix_col_q, pix_col_d;
  logic [COLOR_W-1:0]   pix_data_q, pix_data_d;
  logic                 pix_last_q, pix_last_d;

  logic                 grant_found;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      cand;

  // Winner search: first requesting index starting after the last grant.
  always_comb begin
    grant_found = 1'b0;
    gnt_id      = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      cand = ID_W'(i);
`else
      cand = ID_W'((int'(last_grant_q) + i + 1) % NUM_REQ);
`endif
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        gnt_id      = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_row_d   = rom_row_q;
    rom_col_d   = rom_col_q;
    rom_frame_d = rom_frame_q;
    ack_d       = '0;
    cur_id_d    = cur_id_q;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    // Tag stage 1 mirrors the address register; stage 2 lines up with rom_data.
    s1_valid_d  = (state_q == ISSUE);
    s1_id_d     = cur_id_q;
    s1_col_d    = rom_col_q;
    s1_last_d   = (state_q == ISSUE) && (rom_col_q == 4'd15);
    pix_valid_d = s1_valid_q;
    pix_id_d    = s1_id_q;
    pix_col_d   = s1_col_q;
    pix_last_d  = s1_last_q;
    pix_data_d  = s1_valid_q ? rom_data : pix_data_q;

    if (state_q == ISSUE && rom_col_q != 4'd15) begin
      rom_col_d = rom_col_q + 4'd1;
    end else if (grant_found) begin
      state_d     = ISSUE;
      rom_row_d   = req_row[{gnt_id, 2'b00} +: 4];
      rom_frame_d = req_frame[gnt_id*FRAME_W +: FRAME_W];
      rom_col_d   = '0;
      ack_d[gnt_id] = 1'b1;
      cur_id_d    = gnt_id;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      last_grant_d = gnt_id;
`endif
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rom_row_q   <= '0;
      rom_col_q   <= '0;
      rom_frame_q <= '0;
      ack_q       <= '0;
      cur_id_q    <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_col_q    <= '0;
      s1_last_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_id_q    <= '0;
      pix_col_q   <= '0;
      pix_data_q  <= '0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_row_q   <= rom_row_d;
      rom_col_q   <= rom_col_d;
      rom_frame_q <= rom_frame_d;
      ack_q       <= ack_d;
      cur_id_q    <= cur_id_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_col_q    <= s1_col_d;
      s1_last_q   <= s1_last_d;
      pix_valid_q <= pix_valid_d;
      pix_id_q    <= pix_id_d;
      pix_col_q   <= pix_col_d;
      pix_data_q  <= pix_data_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign ack       = ack_q;
  assign rom_row   = rom_row_q;
  assign rom_col   = rom_col_q;
  assign rom_frame = rom_frame_q;
  assign pix_valid = pix_valid_q;
  assign pix_id    = pix_id_q;
  assign pix_col   = pix_col_q;
  assign pix_data  = pix_data_q;
  assign pix_last  = pix_last_q;
  assign busy      = (state_q == ISSUE) | s1_valid_q | pix_valid_q;

endmodule

// File: tb/tb_sprite_fetch_arb.sv
// Directed bench for sprite_fetch_arb with a registered ROM model.
// Define SPRITE_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_sprite_fetch_arb;
  localparam int NUM_REQ = 4;
  localparam int FRAME_W = 2;
  localparam int COLOR_W = 12;
  localparam int ID_W    = 2;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*4-1:0]       req_row;
  logic [NUM_REQ*FRAME_W-1:0] req_frame;
  logic [NUM_REQ-1:0]         ack;
  logic [3:0]                 rom_row;
  logic [3:0]                 rom_col;
  logic [FRAME_W-1:0]         rom_frame;
  logic [COLOR_W-1:0]         rom_data;
  logic                       pix_valid;
  logic [ID_W-1:0]            pix_id;
  logic [3:0]                 pix_col;
  logic [COLOR_W-1:0]         pix_data;
  logic                       pix_last;
  logic                       busy;

  int errors = 0;
  int checks = 0;

  logic [3:0]         row_tab   [NUM_REQ] = '{4'd3, 4'd5, 4'd10, 4'd12};
  logic [FRAME_W-1:0] frame_tab [NUM_REQ] = '{2'd2, 2'd1, 2'd3, 2'd0};
  int exp_ids[$];

  sprite_fetch_arb #(
    .NUM_REQ(NUM_REQ),
    .FRAME_W(FRAME_W),
    .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_row(req_row),
    .req_frame(req_frame),
    .ack(ack),
    .rom_row(rom_row),
    .rom_col(rom_col),
    .rom_frame(rom_frame),
    .rom_data(rom_data),
    .pix_valid(pix_valid),
    .pix_id(pix_id),
    .pix_col(pix_col),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [COLOR_W-1:0] romWord(input logic [3:0] r, input logic [3:0] c,
                                                 input logic [FRAME_W-1:0] f);
    return {2'b10, r, c, f};
  endfunction

  // ROM returns the word for the address presented in the previous cycle.
  always @(posedge clk) rom_data <= romWord(rom_row, rom_col, rom_frame);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
    req = r;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_row[4*i +: 4]             = row_tab[i];
      req_frame[FRAME_W*i +: FRAME_W] = frame_tab[i];
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " ack"}, 32'(ack), 0);
    checkOutput({name, " rom_row"}, 32'(rom_row), 0);
    checkOutput({name, " rom_col"}, 32'(rom_col), 0);
    checkOutput({name, " rom_frame"}, 32'(rom_frame), 0);
    checkOutput({name, " pix_valid"}, 32'(pix_valid), 0);
    checkOutput({name, " pix_id"}, 32'(pix_id), 0);
    checkOutput({name, " pix_col"}, 32'(pix_col), 0);
    checkOutput({name, " pix_data"}, 32'(pix_data), 0);
    checkOutput({name, " pix_last"}, 32'(pix_last), 0);
    checkOutput({name, " busy"}, 32'(busy), 0);
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus('0);
    repeat (2) @(negedge clk);
    checkAllZero(name);
    reset_n = 1'b1;
  endtask

  // Called at a negedge with inputs already set; exp_ids lists the granted ids in order.
  task automatic runStream(input string name, input int nb, input int drop_col);
    int total, b, c, id, p, pb, pc, pid;
    string t;
    total = 16 * nb;
    for (int k = 1; k <= total + 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      t = $sformatf("%s k=%0d", name, k);
      if (k <= total) begin
        b  = (k - 1) / 16;
        c  = (k - 1) % 16;
        id = exp_ids[b];
        checkOutput({t, " rom_col"}, 32'(rom_col), c);
        checkOutput({t, " rom_row"}, 32'(rom_row), 32'(row_tab[id]));
        checkOutput({t, " rom_frame"}, 32'(rom_frame), 32'(frame_tab[id]));
        checkOutput({t, " ack"}, 32'(ack), (c == 0) ? (1 << id) : 0);
        if (b == nb - 1 && c == drop_col) req = '0;
      end else begin
        checkOutput({t, " ack"}, 32'(ack), 0);
      end
      p = k - 3;
      if (p >= 0 && p < total) begin
        pb  = p / 16;
        pc  = p % 16;
        pid = exp_ids[pb];
        checkOutput({t, " pix_valid"}, 32'(pix_valid), 1);
        checkOutput({t, " pix_id"}, 32'(pix_id), pid);
        checkOutput({t, " pix_col"}, 32'(pix_col), pc);
        checkOutput({t, " pix_last"}, 32'(pix_last), (pc == 15) ? 1 : 0);
        checkOutput({t, " pix_data"}, 32'(pix_data),
                    32'(romWord(row_tab[pid], 4'(pc), frame_tab[pid])));
      end else begin
        checkOutput({t, " pix_valid"}, 32'(pix_valid), 0);
      end
      checkOutput({t, " busy"}, 32'(busy), (k <= total + 2) ? 1 : 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus('0);
    repeat (3) @(negedge clk);

    $display("[TB] single request from requester 1");
    doReset("reset");
    exp_ids = '{1};
    applyStimulus(4'b0010);
    runStream("single", 1, 0);

    $display("[TB] all requesters held");
    doReset("reset2");
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    applyStimulus(4'b1111);
    runStream("rr", 5, 0);

    $display("[TB] requester 2 drops req mid-burst");
    exp_ids = '{2};
    applyStimulus(4'b0100);
    runStream("drop", 1, 7);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(4'b0100);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) req = '0;
    end
    checkOutput("rstmid rom_col before reset", 32'(rom_col), 9);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("rstmid");
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rstmid quiet%0d pix_valid", k), 32'(pix_valid), 0);
      checkOutput($sformatf("rstmid quiet%0d busy", k), 32'(busy), 0);
      checkOutput($sformatf("rstmid quiet%0d ack", k), 32'(ack), 0);
    end
    exp_ids = '{0};
    applyStimulus(4'b1111);
    runStream("regrant", 1, 0);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    $display("[TB] fixed priority with requesters 0 and 3");
    doReset("reset3");
    exp_ids = '{0, 0, 0};
    applyStimulus(4'b1001);
    runStream("fixed", 3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
